// File: rtl/mips_hazard_pkg.sv
// Shared types for the MIPS hazard scoreboard.
//   fwd_sel_t   : Execute operand source select (register file / Writeback / Memory).
//   hz_entry_t  : register-use record kept per pipeline stage.
//   HZ_BUBBLE   : all-zero entry representing an empty slot.
//   reg_match   : register equality that never matches on $0.
package mips_hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dst;
    logic       regwrite;
    logic       memtoreg;
  } hz_entry_t;

  localparam hz_entry_t HZ_BUBBLE = '0;

  // $0 is hardwired to zero, so it can never carry a dependency.
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

endpackage

// File: rtl/hazard_shadow_reg.sv
// One pipeline-stage shadow entry.
//   clk_i   : clock
//   reset_i : synchronous active-high reset, loads a bubble
//   flush_i : load a bubble instead of d_i
//   d_i     : entry from the previous stage
//   q_o     : registered entry
module hazard_shadow_reg
  import mips_hazard_pkg::*;
(
  input  logic      clk_i,
  input  logic      reset_i,
  input  logic      flush_i,
  input  hz_entry_t d_i,
  output hz_entry_t q_o
);

  hz_entry_t entry_d, entry_q;

  always_comb begin
    entry_d = flush_i ? HZ_BUBBLE : d_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      entry_q <= HZ_BUBBLE;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign q_o = entry_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard detection and forwarding control for the five-stage MIPS pipeline.
//   Inputs : Decode rs/rt/dst and control bits (regwrite, memtoreg, branch, pcsrc).
//   Outputs: stall_f_o/stall_d_o/flush_e_o (stall), flush_d_o (taken branch),
//            fwd_a/b_d_o (Memory ALU result into branch comparator),
//            fwd_a/b_e_o (Execute operand select), stall/flush event counters.
// All control outputs are combinational from the E/M/W shadows and Decode inputs.
module hazard_scoreboard
  import mips_hazard_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [4:0]       rs_d_i,
  input  logic [4:0]       rt_d_i,
  input  logic [4:0]       dst_d_i,
  input  logic             regwrite_d_i,
  input  logic             memtoreg_d_i,
  input  logic             branch_d_i,
  input  logic             pcsrc_d_i,
  output logic             stall_f_o,
  output logic             stall_d_o,
  output logic             flush_d_o,
  output logic             flush_e_o,
  output logic             fwd_a_d_o,
  output logic             fwd_b_d_o,
  output logic [1:0]       fwd_a_e_o,
  output logic [1:0]       fwd_b_e_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  hz_entry_t dec_entry, ent_e, ent_m, ent_w;
  logic      lwstall, brstall, stall, flush_d;
  fwd_sel_t  fwd_a_e, fwd_b_e;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q, flush_cnt_d, flush_cnt_q;

  always_comb begin
    dec_entry          = HZ_BUBBLE;
    dec_entry.rs       = rs_d_i;
    dec_entry.rt       = rt_d_i;
    dec_entry.dst      = dst_d_i;
    dec_entry.regwrite = regwrite_d_i;
    dec_entry.memtoreg = memtoreg_d_i;
  end

  // A stalled Decode instruction is replaced by a bubble in E; it re-issues next cycle.
  hazard_shadow_reg u_shadow_e (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .flush_i (stall),
    .d_i     (dec_entry),
    .q_o     (ent_e)
  );

  hazard_shadow_reg u_shadow_m (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .flush_i (1'b0),
    .d_i     (ent_e),
    .q_o     (ent_m)
  );

  hazard_shadow_reg u_shadow_w (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .flush_i (1'b0),
    .d_i     (ent_m),
    .q_o     (ent_w)
  );

  always_comb begin
    lwstall = ent_e.memtoreg &&
              (reg_match(rs_d_i, ent_e.rt) || reg_match(rt_d_i, ent_e.rt));
    // Branches compare in Decode, so they must wait for ALU results in E
    // and for load data still in M.
    brstall = branch_d_i &&
              ((ent_e.regwrite &&
                (reg_match(ent_e.dst, rs_d_i) || reg_match(ent_e.dst, rt_d_i))) ||
               (ent_m.memtoreg &&
                (reg_match(ent_m.dst, rs_d_i) || reg_match(ent_m.dst, rt_d_i))));
    stall   = lwstall || brstall;
    flush_d = pcsrc_d_i && !stall;
  end

  // Memory stage has the newer value, so it takes priority over Writeback.
  always_comb begin
    fwd_a_e = FWD_RF;
    if (ent_m.regwrite && reg_match(ent_m.dst, ent_e.rs)) begin
      fwd_a_e = FWD_MEM;
    end else if (ent_w.regwrite && reg_match(ent_w.dst, ent_e.rs)) begin
      fwd_a_e = FWD_WB;
    end
    fwd_b_e = FWD_RF;
    if (ent_m.regwrite && reg_match(ent_m.dst, ent_e.rt)) begin
      fwd_b_e = FWD_MEM;
    end else if (ent_w.regwrite && reg_match(ent_w.dst, ent_e.rt)) begin
      fwd_b_e = FWD_WB;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q + CNT_W'(stall);
    flush_cnt_d = flush_cnt_q + CNT_W'(flush_d);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_f_o   = stall;
  assign stall_d_o   = stall;
  assign flush_e_o   = stall;
  assign flush_d_o   = flush_d;
  assign fwd_a_d_o   = ent_m.regwrite && reg_match(ent_m.dst, rs_d_i);
  assign fwd_b_d_o   = ent_m.regwrite && reg_match(ent_m.dst, rt_d_i);
  assign fwd_a_e_o   = fwd_a_e;
  assign fwd_b_e_o   = fwd_b_e;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed pipeline sequences plus
// randomized instruction streams, all checked against a stage-list reference model.
module tb_hazard_scoreboard;

  localparam int CNT_W = 4;
  localparam int CMOD  = 1 << CNT_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_i;
  logic [4:0] rs_d, rt_d, dst_d;
  logic       rw_d, mr_d, br_d, pc_d;
  logic       stall_f, stall_d, flush_d, flush_e, fwd_a_d, fwd_b_d;
  logic [1:0] fwd_a_e, fwd_b_e;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  hazard_scoreboard #(.CNT_W(CNT_W)) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .rs_d_i       (rs_d),
    .rt_d_i       (rt_d),
    .dst_d_i      (dst_d),
    .regwrite_d_i (rw_d),
    .memtoreg_d_i (mr_d),
    .branch_d_i   (br_d),
    .pcsrc_d_i    (pc_d),
    .stall_f_o    (stall_f),
    .stall_d_o    (stall_d),
    .flush_d_o    (flush_d),
    .flush_e_o    (flush_e),
    .fwd_a_d_o    (fwd_a_d),
    .fwd_b_d_o    (fwd_b_d),
    .fwd_a_e_o    (fwd_a_e),
    .fwd_b_e_o    (fwd_b_e),
    .stall_cnt_o  (stall_cnt),
    .flush_cnt_o  (flush_cnt)
  );

  // Reference model: instructions in flight, index 0 = Execute, 1 = Memory, 2 = Writeback.
  typedef struct {
    int rs;
    int rt;
    int dst;
    bit rw;
    bit mr;
  } instr_t;

  instr_t pipe[3];
  int     m_stall_cnt, m_flush_cnt;
  bit     exp_stall, exp_flush;
  int     n_checks = 0;
  int     n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit uses(input int reg_a, input int reg_b);
    return reg_a != 0 && reg_a == reg_b;
  endfunction

  function automatic int fwd_src(input int src);
    if (pipe[1].rw && uses(src, pipe[1].dst)) return 2;
    if (pipe[2].rw && uses(src, pipe[2].dst)) return 1;
    return 0;
  endfunction

  // Present one Decode instruction and check every output against the model.
  task automatic drive(input int rs, input int rt, input int dst, input bit rw, input bit mr,
                       input bit br, input bit pc, input bit rst);
    bit lw, brs;
    reset_i = rst;
    rs_d = 5'(rs); rt_d = 5'(rt); dst_d = 5'(dst);
    rw_d = rw; mr_d = mr; br_d = br; pc_d = pc;
    @(negedge clk);
    lw  = pipe[0].mr && (uses(rs, pipe[0].rt) || uses(rt, pipe[0].rt));
    brs = br && ((pipe[0].rw && (uses(rs, pipe[0].dst) || uses(rt, pipe[0].dst))) ||
                 (pipe[1].mr && (uses(rs, pipe[1].dst) || uses(rt, pipe[1].dst))));
    exp_stall = lw || brs;
    exp_flush = pc && !exp_stall;
    check_eq("stall_f", 32'(stall_f), 32'(exp_stall));
    check_eq("stall_d", 32'(stall_d), 32'(exp_stall));
    check_eq("flush_e", 32'(flush_e), 32'(exp_stall));
    check_eq("flush_d", 32'(flush_d), 32'(exp_flush));
    check_eq("fwd_a_d", 32'(fwd_a_d), 32'(pipe[1].rw && uses(rs, pipe[1].dst)));
    check_eq("fwd_b_d", 32'(fwd_b_d), 32'(pipe[1].rw && uses(rt, pipe[1].dst)));
    check_eq("fwd_a_e", 32'(fwd_a_e), 32'(fwd_src(pipe[0].rs)));
    check_eq("fwd_b_e", 32'(fwd_b_e), 32'(fwd_src(pipe[0].rt)));
    check_eq("stall_cnt", 32'(stall_cnt), 32'(m_stall_cnt));
    check_eq("flush_cnt", 32'(flush_cnt), 32'(m_flush_cnt));
  endtask

  task automatic tick();
    instr_t cur, bub;
    bub = '{0, 0, 0, 1'b0, 1'b0};
    cur = '{int'(rs_d), int'(rt_d), int'(dst_d), rw_d, mr_d};
    @(posedge clk);
    if (reset_i) begin
      pipe = '{bub, bub, bub};
      m_stall_cnt = 0;
      m_flush_cnt = 0;
    end else begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = exp_stall ? bub : cur;
      m_stall_cnt = (m_stall_cnt + int'(exp_stall)) % CMOD;
      m_flush_cnt = (m_flush_cnt + int'(exp_flush)) % CMOD;
    end
    #1;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int prev;
    int r_rs, r_rt, r_dst;
    bit r_rw, r_mr, r_br, r_pc;
    pipe = '{'{0, 0, 0, 1'b0, 1'b0}, '{0, 0, 0, 1'b0, 1'b0}, '{0, 0, 0, 1'b0, 1'b0}};
    m_stall_cnt = 0;
    m_flush_cnt = 0;
    #1;
    // Reset; pipe model starts as bubbles, so outputs are checked at the reset cycle too.
    drive(0, 0, 0, 0, 0, 0, 0, 1); tick();
    nop();
    check_eq("rst_stall", 32'(stall_d), 32'd0);
    check_eq("rst_cnt", 32'(stall_cnt), 32'd0);
    tick();

    // add $3,$1,$2 ; sub $4,$3,$5 ; or $7,$3,$0
    drive(1, 2, 3, 1, 0, 0, 0, 0); tick();
    drive(3, 5, 4, 1, 0, 0, 0, 0); tick();
    drive(3, 0, 7, 1, 0, 0, 0, 0);
    check_eq("ex_fwd_mem", 32'(fwd_a_e), 32'd2);
    check_eq("ex_nostall", 32'(stall_d), 32'd0);
    tick();
    nop();
    check_eq("ex_fwd_wb", 32'(fwd_a_e), 32'd1);
    tick();

    // lw $2,0($0) ; and $6,$2,$7
    prev = m_stall_cnt;
    drive(0, 2, 2, 1, 1, 0, 0, 0); tick();
    drive(2, 7, 6, 1, 0, 0, 0, 0);
    check_eq("lu_stall", 32'(stall_f), 32'd1);
    tick();
    drive(2, 7, 6, 1, 0, 0, 0, 0);
    check_eq("lu_one_cycle", 32'(stall_d), 32'd0);
    tick();
    nop();
    check_eq("lu_fwd_wb", 32'(fwd_a_e), 32'd1);
    check_eq("lu_cnt", 32'(stall_cnt), 32'((prev + 1) % CMOD));
    tick();

    // add $8 ; beq $8,$9
    drive(1, 2, 8, 1, 0, 0, 0, 0); tick();
    drive(8, 9, 0, 0, 0, 1, 0, 0);
    check_eq("br_alu_stall", 32'(stall_d), 32'd1);
    tick();
    drive(8, 9, 0, 0, 0, 1, 0, 0);
    check_eq("br_alu_clear", 32'(stall_d), 32'd0);
    check_eq("br_fwd_d", 32'(fwd_a_d), 32'd1);
    tick();

    // lw $8 ; beq $8,$9 -> two stall cycles
    drive(0, 8, 8, 1, 1, 0, 0, 0); tick();
    drive(8, 9, 0, 0, 0, 1, 0, 0);
    check_eq("br_lw_stall1", 32'(stall_d), 32'd1); tick();
    drive(8, 9, 0, 0, 0, 1, 0, 0);
    check_eq("br_lw_stall2", 32'(stall_d), 32'd1); tick();
    drive(8, 9, 0, 0, 0, 1, 0, 0);
    check_eq("br_lw_clear", 32'(stall_d), 32'd0);
    check_eq("br_lw_fwd_d", 32'(fwd_a_d), 32'd0);
    tick();

    // Write to $0 then read $0
    drive(1, 2, 0, 1, 0, 0, 0, 0); tick();
    drive(0, 0, 5, 1, 0, 1, 0, 0);
    check_eq("z_stall", 32'(stall_d), 32'd0);
    tick();
    nop();
    check_eq("z_fwd_a_e", 32'(fwd_a_e), 32'd0);
    check_eq("z_fwd_b_e", 32'(fwd_b_e), 32'd0);
    tick();

    // Taken branch with no hazard, then taken branch under brstall
    prev = m_flush_cnt;
    drive(0, 0, 0, 0, 0, 1, 1, 0);
    check_eq("pc_flush", 32'(flush_d), 32'd1);
    tick();
    nop();
    check_eq("pc_flush_cnt", 32'(flush_cnt), 32'((prev + 1) % CMOD));
    tick();
    drive(1, 2, 8, 1, 0, 0, 0, 0); tick();
    drive(8, 0, 0, 0, 0, 1, 1, 0);
    check_eq("pc_deferred", 32'(flush_d), 32'd0); tick();
    drive(8, 0, 0, 0, 0, 1, 1, 0);
    check_eq("pc_resolved", 32'(flush_d), 32'd1); tick();

    // Reset during a load-use stall
    drive(0, 2, 2, 1, 1, 0, 0, 0); tick();
    drive(2, 0, 6, 1, 0, 0, 0, 1);
    check_eq("rst_mid_stall", 32'(stall_d), 32'd1);
    tick();
    nop();
    check_eq("rst_after_stall", 32'(stall_d), 32'd0);
    check_eq("rst_after_scnt", 32'(stall_cnt), 32'd0);
    check_eq("rst_after_fcnt", 32'(flush_cnt), 32'd0);
    tick();

    // Drive the stall counter to all-ones, then wrap it
    for (int i = 0; i < CMOD; i++) begin
      drive(0, 2, 2, 1, 1, 0, 0, 0); tick();
      drive(2, 7, 6, 1, 0, 0, 0, 0); tick();
      if (i == CMOD - 2) begin
        nop();
        check_eq("cnt_max", 32'(stall_cnt), 32'(CMOD - 1));
        tick();
      end
    end
    nop();
    check_eq("cnt_wrap", 32'(stall_cnt), 32'd0);
    tick();

    // Random instruction streams over a small register set to provoke hazards.
    r_rs = 0; r_rt = 0; r_dst = 0; r_rw = 0; r_mr = 0; r_br = 0; r_pc = 0;
    for (int i = 0; i < 600; i++) begin
      if (!exp_stall) begin
        r_rs  = $urandom_range(0, 5);
        r_rt  = $urandom_range(0, 5);
        r_dst = $urandom_range(0, 5);
        r_rw  = 1'($urandom_range(0, 3) != 0);
        r_mr  = r_rw && ($urandom_range(0, 2) == 0);
        r_br  = !r_rw && ($urandom_range(0, 1) == 1);
        r_pc  = r_br && ($urandom_range(0, 1) == 1);
      end
      drive(r_rs, r_rt, r_dst, r_rw, r_mr, r_br, r_pc, 1'($urandom_range(0, 63) == 0));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Hazard detection and forwarding control for the five-stage pipelined MIPS core. Consumes the decode-stage register fields (rs, rt, destination) and control bits each cycle. Keeps its own shadow copy of the register-use information for the Execute, Memory and Writeback stages. From that it drives fetch/decode stalls, the Execute flush, decode and execute forwarding selects, and a stall/flush event counter that benches can observe.

## Interface
Parameters:
- CNT_W, 32, width of the stall and flush event counters.

Ports:
- clk_i  in  1  core clock; all state updates on its rising edge.
- reset_i  in  1  reset, synchronous, active-high.
- rs_d_i  in  5  rs field of the instruction in Decode.
- rt_d_i  in  5  rt field of the instruction in Decode.
- dst_d_i  in  5  resolved write register of the Decode instruction (rd or rt, already muxed by regdst).
- regwrite_d_i  in  1  Decode instruction writes the register file.
- memtoreg_d_i  in  1  Decode instruction is a load.
- branch_d_i  in  1  Decode instruction is a beq/bne (compared in Decode).
- pcsrc_d_i  in  1  branch taken, resolved in Decode.
- stall_f_o  out  1  hold PC.
- stall_d_o  out  1  hold the IF/ID register.
- flush_d_o  out  1  clear IF/ID (taken branch).
- flush_e_o  out  1  clear ID/EX (insert bubble).
- fwd_a_d_o, fwd_b_d_o  out  1 each  forward the ALU result from Memory into the Decode branch comparator for rs / rt.
- fwd_a_e_o, fwd_b_e_o  out  2 each  Execute ALU operand select: 00 register file, 01 Writeback result, 10 Memory ALU result.
- stall_cnt_o  out  CNT_W  number of cycles with stall_d_o=1.
- flush_cnt_o  out  CNT_W  number of cycles with flush_d_o=1.

## Operation
- Shadow entries E, M and W each hold: rs, rt, dst, regwrite, memtoreg. A bubble has all fields 0.
- Hazard terms (every comparison also requires the compared register to be non-zero; $0 never creates a hazard):
  - lwstall = memtoreg_E and (rs_d==rt_E or rt_d==rt_E).
  - brstall = branch_d and [(regwrite_E and dst_E ∈ {rs_d, rt_d}) or (memtoreg_M and dst_M ∈ {rs_d, rt_d})].
  - stall = lwstall or brstall.
  - stall_f_o = stall_d_o = flush_e_o = stall.
  - flush_d_o = pcsrc_d_i and not stall.
- Forwarding:
  - fwd_a_e_o = 10 if regwrite_M and dst_M==rs_E; else 01 if regwrite_W and dst_W==rs_E; else 00. Memory has priority over Writeback.
  - fwd_b_e_o uses the same rule with rt_E.
  - fwd_a_d_o = regwrite_M and dst_M==rs_d. fwd_b_d_o uses the same rule with rt_d.
- Shadow update at each clock edge:
  - W ← M and M ← E, always.
  - E ← bubble if flush_e_o, else E ← the Decode fields.
  - When stalled, Decode keeps presenting the same instruction, so it re-evaluates next cycle.
- Counters increment by 1 on each qualifying cycle and wrap modulo 2^CNT_W. No saturation.
- pcsrc_d_i asserted together with stall: the stall wins. The flush is deferred until the branch resolves un-stalled.

## Timing
- All control outputs are combinational from the current shadow state and the Decode inputs. They are valid in the same cycle and have zero latency.
- Shadow state and counters are registered, with one-cycle update.
- Reset (synchronous, any cycle, including mid-stall):
  - E, M, W become bubbles and both counters become 0.
  - After the reset edge, with reset_i still high: all fwd outputs are 0 and flush_d_o follows pcsrc_d_i. stall, flush_e_o and stall_f_o are 0 unless the Decode inputs alone cause a stall. With bubbles in E and M, no stall can occur.
- A load-use stall lasts exactly 1 cycle.
- A branch stall lasts:
  - 1 cycle when the branch depends on an ALU result in E;
  - 2 cycles when it depends on a load in E (lwstall, then brstall on memtoreg_M).

## Structure
- Package mips_hazard_pkg:
  - enum fwd_sel_t: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - struct hz_entry_t {rs, rt, dst, regwrite, memtoreg}.
  - constant HZ_BUBBLE.
- Sub-module hazard_shadow_reg: one hz_entry_t register with synchronous reset and a flush input. It is instantiated three times (E, M, W).
- Top level: combinational compare logic plus the two counters.

## Test plan
- After reset, issue `add $3,$1,$2` then `sub $4,$3,$5` (rs_d=3): the cycle sub is in E gives fwd_a_e_o=10 and no stall. One cycle later, an instruction with rs=3 gets fwd_a_e_o=01.
- `lw $2,0($0)` followed by `and $6,$2,$7`: stall_f_o=stall_d_o=flush_e_o=1 for exactly one cycle. Next cycle fwd_a_e_o=01 and stall_cnt_o=1.
- `add $8,...` followed by `beq $8,$9` (branch_d=1): 1-cycle stall, then fwd_a_d_o=1. `lw $8` followed by `beq $8`: 2-cycle stall, then fwd_a_d_o=0, with data taken from the register file via Writeback.
- Writes to $0 (dst=0, regwrite=1) followed by a reader of rs=0: no stall, all fwd outputs 0.
- pcsrc_d_i=1 with no hazard: flush_d_o=1 and flush_cnt_o increments. pcsrc_d_i=1 during brstall: flush_d_o=0 until the stall clears.
- Assert reset_i for one cycle during a load-use stall: next cycle outputs are 0 and counters are 0. Preload a counter to 2^CNT_W−1 (CNT_W=4): one more stall wraps it to 0.
